alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
// - Shares the single combinational 16-bit ALU between two requesters (req0, req1) using round-robin arbitration.
// - Registers the granted operands and opcode, drives the ALU for one cycle, and captures aluOut/flags.
// - Returns the result to the granted requester on one shared response channel, tagged by requester id.
// - Sits between the decode/issue stage and the ALU.
// PARAMETERS
// - DW  16  operand/result width (R1, R2, aluOut)
// - OPW 8   opcode width
// - FW  5   ALU flags width
// PORTS
// - clk            in  1    clock, rising edge
// - rst_n          in  1    asynchronous active-low reset
// - req0_valid     in  1    requester 0 has an op
// - req0_ready     out 1    requester 0 op accepted this cycle (when valid)
// - req0_r1        in  DW   requester 0 operand R1
// - req0_r2        in  DW   requester 0 operand R2
// - req0_op        in  OPW  requester 0 opcode
// - req1_*         same as req0_* for requester 1
// - alu_r1         out DW   to ALU R1
// - alu_r2         out DW   to ALU R2
// - alu_opcode     out OPW  to ALU opcode
// - alu_out        in  DW   from ALU aluOut
// - alu_flags      in  FW   from ALU flags
// - rsp_valid      out 1    response available
// - rsp_ready      in  1    consumer takes response
// - rsp_id         out 1    requester id of response
// - rsp_data       out DW   captured result
// - rsp_flags      out FW   captured flags
// - rsp_err        out 1    opcode was illegal; data/flags are 0
// - psr_flags      out FW   status register (see CONFIGURATION)
// BEHAVIOUR
// - FSM states: IDLE -> EXEC -> RESP -> IDLE. Reset state is IDLE.
// - IDLE:
//   - req*_ready is combinational: at most one is high, and only for a valid requester.
//   - If only one requester is valid, it is granted.
//   - If both are valid, the one not granted last is granted.
//   - The last-grant pointer resets to 1, so req0 wins the first tie.
// - Accept cycle T (valid & ready):
//   - Register r1, r2, op and id; update the last-grant pointer; go to EXEC.
// - EXEC (T+1):
//   - alu_r1/alu_r2/alu_opcode are driven from the registers.
//   - At the clock edge, capture alu_out/alu_flags into rsp_data/rsp_flags; go to RESP.
// - RESP (T+2 onward):
//   - rsp_valid=1; rsp_* stay stable until rsp_ready=1.
//   - On the handshake cycle, go to IDLE. The next accept is no earlier than the following cycle.
//   - Minimum issue interval is 3 cycles.
// - Legal opcodes:
//   - 0x01 AND, 0x02 OR, 0x03 XOR, 0x05 ADD, 0x06 ADDU, 0x07 ADDC.
//   - 0x08 LSH, 0x09 SUB, 0x0A SUBC, 0x0B CMP, 0x0D MOV, 0x0F ASHU.
// - Illegal opcode:
//   - The op is still accepted; EXEC drives alu_opcode=0x00.
//   - Capture rsp_data=0, rsp_flags=0, rsp_err=1.
// - alu_opcode is 0x00 in IDLE and RESP; alu_r1/alu_r2 hold their last values.
// - req*_ready=0 in EXEC and RESP. Requesters must hold valid and operands until ready.
// - rsp_ready high outside RESP is ignored. A valid request arriving during RESP waits; nothing is dropped.
// - Reset values: state IDLE; rsp_valid/rsp_id/rsp_data/rsp_flags/rsp_err = 0; alu_r1/alu_r2/alu_opcode = 0; psr_flags = 0.
// - Reset mid-operation: the in-flight op is discarded with no response; the arbiter restarts from IDLE with req0 priority.
// CONFIGURATION
// - Macro ALU_ARB_PSR_EN.
// - Defined:
//   - psr_flags is a register, loaded with alu_flags at the EXEC capture edge of every legal op.
//   - It is not updated for illegal ops and holds its value otherwise.
// - Undefined:
//   - No PSR register; psr_flags is tied to 0.
//   - All other behaviour is identical.
// TESTING
// - Single op, ADD (0x05) r1=3, r2=4 on req0 at cycle T:
//   - Expect ready at T, alu_opcode=0x05 at T+1, rsp_valid at T+2.
//   - rsp_id=0, rsp_data=0x0007, rsp_err=0.
// - Tie out of reset, both valid (req0 AND, req1 OR):
//   - req0 is granted first, req1 next.
//   - With both held valid, grants alternate 0,1,0,1 over 4 ops.
// - Backpressure: rsp_ready=0 for 5 cycles with req1 valid:
//   - rsp_* are stable; req1_ready stays 0.
//   - req1 is accepted the cycle after the handshake.
// - Illegal opcode 0x04 on req1:
//   - rsp_err=1, rsp_data=0, rsp_flags=0.
//   - psr_flags is unchanged (with ALU_ARB_PSR_EN defined).
// - Reset asserted in EXEC:
//   - All outputs go to 0 immediately; no response is produced.
//   - After release, a req1-only op is granted in the first IDLE cycle.
// - Build with and without ALU_ARB_PSR_EN, running CMP (0x0B) with r1=r2=5:
//   - psr_flags equals the captured rsp_flags when defined; it is 0 when undefined.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters; accept->EXEC->RESP, response at T+2, held until rsp_ready.
// Optional PSR register under ALU_ARB_PSR_EN; otherwise psr_flags is tied to 0.
module alu_arbiter #(
  parameter int DW  = 16,
  parameter int OPW = 8,
  parameter int FW  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_r1,
  input  logic [DW-1:0]  req0_r2,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_r1,
  input  logic [DW-1:0]  req1_r2,
  input  logic [OPW-1:0] req1_op,
  output logic [DW-1:0]  alu_r1,
  output logic [DW-1:0]  alu_r2,
  output logic [OPW-1:0] alu_opcode,
  input  logic [DW-1:0]  alu_out,
  input  logic [FW-1:0]  alu_flags,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_data,
  output logic [FW-1:0]  rsp_flags,
  output logic           rsp_err,
  output logic [FW-1:0]  psr_flags
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state_q, state_d;
  logic           last_q;
  logic [DW-1:0]  r1_q, r2_q;
  logic [OPW-1:0] op_q;
  logic           id_q;
  logic           legal_q;
  logic           rsp_id_q;
  logic [DW-1:0]  rsp_data_q;
  logic [FW-1:0]  rsp_flags_q;
  logic           rsp_err_q;
  logic           grant0, grant1;
  logic [OPW-1:0] sel_op;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    case (op)
      OPW'(8'h01), OPW'(8'h02), OPW'(8'h03), OPW'(8'h05),
      OPW'(8'h06), OPW'(8'h07), OPW'(8'h08), OPW'(8'h09),
      OPW'(8'h0A), OPW'(8'h0B), OPW'(8'h0D), OPW'(8'h0F): op_legal = 1'b1;
      default:                                            op_legal = 1'b0;
    endcase
  endfunction

  // last_q==1 means req1 was granted last, so req0 wins a tie; ready is held low during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state_q == IDLE) begin
      grant0 = req0_valid && (!req1_valid || last_q);
      grant1 = req1_valid && (!req0_valid || !last_q);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sel_op     = grant1 ? req1_op : req0_op;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant0 || grant1) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      r1_q        <= '0;
      r2_q        <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      legal_q     <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant0 || grant1) begin
        r1_q    <= grant1 ? req1_r1 : req0_r1;
        r2_q    <= grant1 ? req1_r2 : req0_r2;
        op_q    <= sel_op;
        id_q    <= grant1;
        last_q  <= grant1;
        legal_q <= op_legal(sel_op);
      end
      if (state_q == EXEC) begin
        rsp_id_q    <= id_q;
        rsp_data_q  <= legal_q ? alu_out : '0;
        rsp_flags_q <= legal_q ? alu_flags : '0;
        rsp_err_q   <= !legal_q;
      end
    end
  end

  // Operand buses hold their last values; only the opcode is squashed outside a legal EXEC.
  assign alu_r1     = r1_q;
  assign alu_r2     = r2_q;
  assign alu_opcode = (state_q == EXEC && legal_q) ? op_q : '0;

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

`ifdef ALU_ARB_PSR_EN
  logic [FW-1:0] psr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psr_q <= '0;
    end else if (state_q == EXEC && legal_q) begin
      psr_q <= alu_flags;
    end
  end

  assign psr_flags = psr_q;
`else
  assign psr_flags = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU stand-in driving alu_out/alu_flags.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_r1, req0_r2, req1_r1, req1_r2;
  logic [7:0]  req0_op, req1_op;
  logic [15:0] alu_r1, alu_r2, alu_out;
  logic [7:0]  alu_opcode;
  logic [4:0]  alu_flags;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_flags, psr_flags;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_psr;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_r1(req0_r1), .req0_r2(req0_r2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_r1(req1_r1), .req1_r2(req1_r2), .req1_op(req1_op),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .psr_flags(psr_flags)
  );

  // ALU stand-in: flags = {3'b101, negative, zero}; unknown opcodes give 0xDEAD so squashing is visible.
  always_comb begin
    case (alu_opcode)
      8'h01:               alu_out = alu_r1 & alu_r2;
      8'h02:               alu_out = alu_r1 | alu_r2;
      8'h03:               alu_out = alu_r1 ^ alu_r2;
      8'h05, 8'h06, 8'h07: alu_out = alu_r1 + alu_r2;
      8'h09, 8'h0A, 8'h0B: alu_out = alu_r1 - alu_r2;
      8'h0D:               alu_out = alu_r2;
      default:             alu_out = 16'hDEAD;
    endcase
    alu_flags = {3'b101, alu_out[15], (alu_out == 16'h0000)};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_r1 = 0; req0_r2 = 0; req0_op = 0;
    req1_r1 = 0; req1_r2 = 0; req1_op = 0;
    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_alu_r1", alu_r1, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_psr", psr_flags, 0);
    tick();
    rst_n = 1'b1;

    // Single ADD on req0
    req0_valid = 1; req0_r1 = 16'd3; req0_r2 = 16'd4; req0_op = 8'h05;
    #1;
    check("add_rdy0", req0_ready, 1);
    check("add_rdy1", req1_ready, 0);
    tick();
    req0_valid = 0;
    check("add_exec_op", alu_opcode, 8'h05);
    check("add_exec_r1", alu_r1, 16'd3);
    check("add_exec_vld", rsp_valid, 0);
    tick();
    check("add_rsp_vld", rsp_valid, 1);
    check("add_rsp_id", rsp_id, 0);
    check("add_rsp_data", rsp_data, 16'h0007);
    check("add_rsp_err", rsp_err, 0);
    check("add_rsp_flags", rsp_flags, 5'h14);
    check("add_resp_opcode", alu_opcode, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("add_idle_vld", rsp_valid, 0);

    // Tie out of reset: grants alternate 0,1,0,1
    do_reset();
    req0_valid = 1; req0_op = 8'h01; req0_r1 = 16'h00FF; req0_r2 = 16'h0F0F;
    req1_valid = 1; req1_op = 8'h02; req1_r1 = 16'h1200; req1_r2 = 16'h0034;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("tie_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
      check("tie_rdy1", req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      tick();
      check("tie_rsp_id", rsp_id, i % 2);
      check("tie_rsp_data", rsp_data, (i % 2 == 0) ? 16'h000F : 16'h1234);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
    end

    // Backpressure with req1 waiting; req0 wins since req1 was granted last
    #1;
    check("bp_rdy0", req0_ready, 1);
    tick();
    req0_valid = 0;
    req1_op = 8'h04;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", rsp_valid, 1);
      check("bp_id", rsp_id, 0);
      check("bp_data", rsp_data, 16'h000F);
      check("bp_rdy1", req1_ready, 0);
      tick();
    end
`ifdef ALU_ARB_PSR_EN
    exp_psr = 5'h14;
`else
    exp_psr = 5'h00;
`endif
    check("bp_psr", psr_flags, exp_psr);
    rsp_ready = 1;
    #1;
    check("bp_hs_rdy1", req1_ready, 0);
    tick();
    rsp_ready = 0;
    check("bp_after_vld", rsp_valid, 0);
    check("bp_after_rdy1", req1_ready, 1);

    // Illegal opcode 0x04 on req1
    tick();
    req1_valid = 0;
    check("ill_exec_op", alu_opcode, 0);
    tick();
    check("ill_vld", rsp_valid, 1);
    check("ill_id", rsp_id, 1);
    check("ill_err", rsp_err, 1);
    check("ill_data", rsp_data, 0);
    check("ill_flags", rsp_flags, 0);
    check("ill_psr", psr_flags, exp_psr);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // Reset asserted during EXEC
    req0_valid = 1; req0_op = 8'h05; req0_r1 = 16'd10; req0_r2 = 16'd20;
    tick();
    check("rx_exec_op", alu_opcode, 8'h05);
    rst_n = 0;
    #1;
    check("rx_opcode", alu_opcode, 0);
    check("rx_alu_r1", alu_r1, 0);
    check("rx_vld", rsp_valid, 0);
    check("rx_rdy0", req0_ready, 0);
    check("rx_psr", psr_flags, 0);
    req0_valid = 0;
    req1_valid = 1; req1_op = 8'h0D; req1_r1 = 16'h0000; req1_r2 = 16'hBEEF;
    rst_n = 1;
    #1;
    check("rx_rdy1", req1_ready, 1);
    tick();
    req1_valid = 0;
    check("rx_no_rsp", rsp_valid, 0);
    tick();
    check("rx_rsp_id", rsp_id, 1);
    check("rx_rsp_data", rsp_data, 16'hBEEF);
    check("rx_rsp_flags", rsp_flags, 5'h16);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // CMP 5,5 drives the PSR when enabled
    req0_valid = 1; req0_op = 8'h0B; req0_r1 = 16'd5; req0_r2 = 16'd5;
    tick();
    req0_valid = 0;
    tick();
    check("cmp_data", rsp_data, 0);
    check("cmp_flags", rsp_flags, 5'h15);
`ifdef ALU_ARB_PSR_EN
    exp_psr = 5'h15;
`else
    exp_psr = 5'h00;
`endif
    check("cmp_psr", psr_flags, exp_psr);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("cmp_idle_vld", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
